// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary: pairs synchronous-read instruction data with its fetch PC,
// buffers the pairs in a small FIFO, and drives the PC hold and flush handling.
module if_id_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             fetch_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_plus4_out,
  output logic             valid_out,
  output logic             pc_hold,
  output logic             overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             inflight;
  logic [WIDTH-1:0] inflight_pc;

  logic             pop, push, accept, full, drop, push_ok;
  logic [CW:0]      occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_out    = (count != '0);
  assign instr_out    = valid_out ? mem[rd_ptr].instr : '0;
  assign pc_plus4_out = valid_out ? mem[rd_ptr].pc + WIDTH'(4) : '0;

  assign pop     = valid_out & ~stall & ~flush;
  assign push    = inflight & ~flush;
  assign full    = (count == CW'(DEPTH));
  assign drop    = push & ~pop & full;
  assign push_ok = push & ~drop;

  // Occupancy after this edge if the PC were allowed to issue nothing new;
  // holding once it reaches DEPTH guarantees room for every in-flight response.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign pc_hold   = ~flush & (occupancy >= (CW+1)'(DEPTH));
  assign accept    = fetch_valid & ~pc_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      overflow_err <= 1'b0;
    end else begin
      inflight <= accept & ~flush;
      if (accept) inflight_pc <= pc_in;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= next_ptr(wr_ptr);
        if (pop)     rd_ptr <= next_ptr(rd_ptr);
        case ({push_ok, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (drop) overflow_err <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never visible and the array can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: a bench-side PC and synchronous
// instruction memory feed the DUT; a scoreboard queue predicts the IF/ID head.
module tb_if_id_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] pc_in = '0;
  logic             fetch_valid = 1'b0;
  logic [WIDTH-1:0] imem_rdata = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] instr_out, pc_plus4_out;
  logic             valid_out, pc_hold, overflow_err;

  if_id_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_valid(fetch_valid),
    .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .valid_out(valid_out),
    .pc_hold(pc_hold), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] instr;
  } exp_t;

  exp_t             sb[$];
  logic             m_inflight = 1'b0;
  logic [WIDTH-1:0] m_inflight_pc = '0;
  logic [WIDTH-1:0] pc = '0;
  logic [WIDTH-1:0] rdata_next = '0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] instr_of(input logic [WIDTH-1:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      32'h0000_0008: return 32'h0109_5020;
      default:       return a ^ 32'hA5C3_0000;
    endcase
  endfunction

  // One clock cycle: drive inputs after the falling edge, check settled
  // outputs against the model, then advance the model across the rising edge.
  task automatic cyc(input logic fv, input logic st, input logic fl,
                     input logic rst, input logic [WIDTH-1:0] tgt);
    logic exp_valid, exp_pop, exp_hold, exp_accept, exp_push;
    int   occ;
    @(negedge clk);
    fetch_valid = fv;
    stall       = st;
    flush       = fl;
    reset       = rst;
    pc_in       = pc;
    imem_rdata  = rdata_next;
    #1;
    exp_valid  = (sb.size() != 0);
    exp_pop    = exp_valid & ~st & ~fl;
    occ        = sb.size() + int'(m_inflight) - int'(exp_pop);
    exp_hold   = ~fl & (occ >= DEPTH);
    exp_accept = fv & ~exp_hold;
    exp_push   = m_inflight & ~fl;
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("instr_out", instr_out, exp_valid ? sb[0].instr : '0);
    check("pc_plus4_out", pc_plus4_out, exp_valid ? sb[0].pc4 : '0);
    check("pc_hold", 32'(pc_hold), 32'(exp_hold));
    check("overflow_err", 32'(overflow_err), 32'd0);
    rdata_next = instr_of(pc_in);
    if (rst) begin
      sb.delete();
      m_inflight    = 1'b0;
      m_inflight_pc = '0;
      pc            = '0;
    end else begin
      if (fl) begin
        sb.delete();
      end else begin
        if (exp_pop) void'(sb.pop_front());
        if (exp_push) sb.push_back('{pc4: m_inflight_pc + 32'd4, instr: imem_rdata});
      end
      m_inflight = exp_accept & ~fl;
      if (exp_accept) m_inflight_pc = pc_in;
      if (fl) pc = tgt;
      else if (exp_accept) pc = pc + 32'd4;
    end
  endtask

  initial begin
    // 1: plain streaming from address 0
    repeat (2) cyc(0, 0, 0, 1, '0);
    repeat (3) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // 2: stream, then a 3-cycle stall; nothing lost or duplicated afterwards
    cyc(0, 0, 0, 1, '0);
    repeat (3) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(1, 1, 0, 0, '0);
    repeat (4) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // 3: flush with one entry queued and 0x10 in flight; redirect to 0x40
    cyc(0, 0, 0, 1, '0);
    repeat (4) cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 1, 0, 32'h40);
    repeat (3) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // 4: flush and stall together while full
    cyc(0, 0, 0, 1, '0);
    repeat (4) cyc(1, 1, 0, 0, '0);
    cyc(1, 1, 1, 0, 32'h80);
    repeat (3) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // 5: PC+4 wraps at the top of the address space
    cyc(0, 0, 1, 0, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // 6: reset while full; first fetch afterwards has normal latency
    cyc(0, 0, 1, 0, 32'h100);
    repeat (4) cyc(1, 1, 0, 0, '0);
    cyc(1, 1, 0, 1, '0);
    repeat (2) cyc(1, 0, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);

    // Random mix of fetch, stall, flush and occasional reset
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 9) < 3),
          logic'($urandom_range(0, 99) < 8),
          logic'($urandom_range(0, 99) == 0),
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    // Drain: with fetch and stall low the queue must empty within a bound
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    check("drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- IF/ID boundary stage, directly downstream of the program counter. Its input is the PC address currently driving instruction memory.
- Instruction memory has synchronous read: data returns one cycle after the address.
- The block pairs each returned instruction with its fetch PC. It holds the pairs in a small FIFO so that fetches already in flight survive ID-stage stalls.
- It presents the FIFO head to ID as the IF/ID register contents. It generates the PC hold (enable) control and discards wrong-path fetches on branch/jump flush.

Parameters:
- WIDTH, 32, instruction and address width.
- DEPTH, 2, FIFO entries. Minimum 2.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  WIDTH  address presented to instruction memory this cycle (the PC output).
- fetch_valid  in  1  pc_in is a real fetch request this cycle.
- imem_rdata  in  WIDTH  instruction-memory read data for the address presented in the previous cycle.
- stall  in  1  ID cannot accept the head entry this cycle.
- flush  in  1  branch/jump redirect from ID. Kills all younger fetches.
- instr_out  out  WIDTH  head instruction. 0 (NOP) when valid_out=0.
- pc_plus4_out  out  WIDTH  head fetch PC + 4, modulo 2^WIDTH. 0 when valid_out=0.
- valid_out  out  1  head entry present.
- pc_hold  out  1  1 = PC must not update. Drives the PC enable input; the PC loads only when this is low.
- overflow_err  out  1  sticky. Set if a push ever hits a full FIFO.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - count=0, inflight=0, inflight_pc=0, overflow_err=0.
  - Outputs: valid_out=0, instr_out=0, pc_plus4_out=0, pc_hold=0.
  - Reset overrides flush, stall and all other inputs.
- Internal signals:
  - pop = valid_out & ~stall & ~flush.
  - push = inflight & ~flush. The pushed entry is {inflight_pc, imem_rdata}.
  - pc_hold = ~flush & ((count + inflight - pop) >= DEPTH). This is combinational and includes a stall->pc_hold path.
  - accept = fetch_valid & ~pc_hold.
- In-flight tracking, each edge:
  - inflight <= accept & ~flush.
  - inflight_pc <= pc_in when accept.
  - A fetch issued in a flush cycle is from the wrong path and is never pushed.
- FIFO update:
  - Circular rd/wr pointers modulo DEPTH.
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - Head outputs reflect the rd pointer combinationally from FIFO storage. Zeros are forced when count=0.
- Latency:
  - Fetch accepted in cycle n -> data at imem_rdata in n+1 -> valid_out=1 in n+2, provided no flush in n or n+1.
  - Full throughput (one instruction per cycle) when stall=0.
- Stall:
  - Head entry and outputs hold stable.
  - The in-flight response is still pushed.
  - pc_hold rises once count+inflight reaches DEPTH. No fetch is lost.
- Flush (priority over stall):
  - Next edge: count=0, pointers=0, inflight=0.
  - The response arriving during the flush cycle is discarded.
  - pc_hold=0 during flush, so the PC loads the redirect target.
  - valid_out=0 in the cycle after flush.
  - The target fetch (cycle after flush) reaches valid_out 2 cycles later.
- Full FIFO with push and no pop: unreachable by the pc_hold construction. If it occurs, the push is dropped, FIFO contents are unchanged, and overflow_err <= 1 until reset.
- Stall while empty: no effect on valid_out (remains 0). The pop condition is not met.
- Reset mid-operation: all queued and in-flight entries are discarded. The first post-reset fetch follows normal latency.

Test Plan:
1. Reset, then fetch_valid=1 with pc_in 0x0,0x4,0x8 and imem returning 0x20080005,0x20090003,0x01095020 one cycle later, stall=0 -> valid_out rises 2 cycles after the first fetch; pc_plus4_out=0x4,0x8,0xC with matching instr_out on consecutive cycles; pc_hold stays 0.
2. Stream as in 1, then stall=1 for 3 cycles -> head held at pc_plus4_out=0x8; pc_hold=1 from the cycle count+inflight reaches 2; after stall drops, instructions 0x8,0xC,0x10 appear in order with none lost or duplicated; overflow_err=0.
3. Flush asserted while count=1 and inflight=1 (pc_in=0x10) -> next cycle valid_out=0 and pc_hold=0; fetch of target 0x40 in the following cycle appears as pc_plus4_out=0x44 two cycles later; 0x10/0x14 never appear.
4. flush=1 and stall=1 in the same cycle with FIFO full -> FIFO emptied, pc_hold=0 in that cycle.
5. fetch at pc_in=0xFFFFFFFC -> pc_plus4_out=0x00000000 with valid_out=1.
6. reset asserted mid-stream with count=2 -> next cycle valid_out=0, instr_out=0, pc_hold=0, overflow_err=0; the next fetch of 0x0 emerges after 2 cycles.
